// File: rtl/complex_mixer.sv
// complex_mixer: pipelined complex multiplier used for DDS mixing and for FFT twiddles.
// It computes (idat_re + j*idat_im) * (icos +/- j*isin) and scales the sum down to pODAT_W
// bits. The scaling either floors the result or rounds half-up.
//
// Ports
//   iclk               clock, rising edge
//   ireset             asynchronous active-low reset; clears every pipeline register
//   iclkena            clock enable shared by every register (data and valid)
//   ival               input sample valid
//   idat_re, idat_im   signed data input, pIDAT_W bits
//   icos, isin         signed oscillator/twiddle, pDDS_W bits
//   oval               output valid, 3 + pUSE_ROUND enabled cycles after ival
//   odat_re, odat_im   signed scaled result, pODAT_W bits
//
// Pipeline: operand registers -> product registers -> sum registers -> (rounding register).
// Data registers capture on every enabled clock, whatever ival is. Only the valid shift
// register tracks which pipeline slots hold real samples.
module complex_mixer #(
    parameter int unsigned pIDAT_W      = 16,
    parameter int unsigned pDDS_W       = 17,
    parameter int unsigned pODAT_W      = 18,
    parameter int unsigned pMUL_W       = 0,
    parameter int unsigned pCONJ        = 0,
    parameter int unsigned pUSE_DSP_ADD = 1,
    parameter int unsigned pUSE_ROUND   = 1
) (
    input  logic                      iclk,
    input  logic                      ireset,
    input  logic                      iclkena,
    input  logic                      ival,
    input  logic signed [pIDAT_W-1:0] idat_re,
    input  logic signed [pIDAT_W-1:0] idat_im,
    input  logic signed [pDDS_W-1:0]  icos,
    input  logic signed [pDDS_W-1:0]  isin,
    output logic                      oval,
    output logic signed [pODAT_W-1:0] odat_re,
    output logic signed [pODAT_W-1:0] odat_im
);

    localparam int unsigned ProdW = pIDAT_W + pDDS_W;
    // Width of each product after optional MSB truncation.
    localparam int unsigned MulW  = (pMUL_W > 0) ? pMUL_W : ProdW;
    // One guard bit is enough: |a*c| + |b*s| <= 2^(ProdW-1), and that bound is reached
    // only when both products are +2^(ProdW-2).
    localparam int unsigned SumW  = MulW + 1;
    localparam int unsigned Shift = SumW - pODAT_W;
    localparam int unsigned Lat   = 3 + pUSE_ROUND;

    // ---------------- stage 1: operand registers ----------------
    logic signed [pIDAT_W-1:0] a_q, b_q;
    logic signed [pDDS_W-1:0]  c_q, s_q;

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            s_q <= '0;
        end else if (iclkena) begin
            a_q <= idat_re;
            b_q <= idat_im;
            c_q <= icos;
            s_q <= isin;
        end
    end

    // ---------------- stage 2: product registers ----------------
    logic signed [ProdW-1:0] ac_full, bs_full, as_full, bc_full;
    logic signed [MulW-1:0]  ac_q, bs_q, as_q, bc_q;

    always_comb begin
        ac_full = a_q * c_q;
        bs_full = b_q * s_q;
        as_full = a_q * s_q;
        bc_full = b_q * c_q;
    end

    // Keeping the top MulW bits is an arithmetic right shift (floor) of each product.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            ac_q <= '0;
            bs_q <= '0;
            as_q <= '0;
            bc_q <= '0;
        end else if (iclkena) begin
            ac_q <= ac_full[ProdW-1 -: MulW];
            bs_q <= bs_full[ProdW-1 -: MulW];
            as_q <= as_full[ProdW-1 -: MulW];
            bc_q <= bc_full[ProdW-1 -: MulW];
        end
    end

    // ---------------- stage 3: sum / difference ----------------
    logic signed [SumW-1:0] ac_x, bs_x, as_x, bc_x;
    logic signed [SumW-1:0] re_sum_q, im_sum_q;

    always_comb begin
        ac_x = {ac_q[MulW-1], ac_q};
        bs_x = {bs_q[MulW-1], bs_q};
        as_x = {as_q[MulW-1], as_q};
        bc_x = {bc_q[MulW-1], bc_q};
    end

    if (pUSE_DSP_ADD != 0) begin : g_dsp_add
        // The add/subtract is written inside the register process. This maps onto the
        // post-adder and output register of the multiplier primitive.
        always_ff @(posedge iclk or negedge ireset) begin
            if (!ireset) begin
                re_sum_q <= '0;
                im_sum_q <= '0;
            end else if (iclkena) begin
                re_sum_q <= (pCONJ != 0) ? ac_x + bs_x : ac_x - bs_x;
                im_sum_q <= (pCONJ != 0) ? bc_x - as_x : as_x + bc_x;
            end
        end
    end else begin : g_fabric_add
        logic signed [SumW-1:0] re_sum_d, im_sum_d;

        always_comb begin
            re_sum_d = (pCONJ != 0) ? ac_x + bs_x : ac_x - bs_x;
            im_sum_d = (pCONJ != 0) ? bc_x - as_x : as_x + bc_x;
        end

        always_ff @(posedge iclk or negedge ireset) begin
            if (!ireset) begin
                re_sum_q <= '0;
                im_sum_q <= '0;
            end else if (iclkena) begin
                re_sum_q <= re_sum_d;
                im_sum_q <= im_sum_d;
            end
        end
    end

    // ---------------- stage 4: scaling ----------------
    if (pUSE_ROUND != 0) begin : g_round
        localparam logic signed [SumW:0] Half = (SumW + 1)'(1) << (Shift - 1);

        logic signed [SumW:0]      re_rnd, im_rnd;
        logic signed [pODAT_W-1:0] re_out_q, im_out_q;
        logic                      unused_rnd;

        // One extra bit so that adding the half-LSB cannot wrap.
        always_comb begin
            re_rnd = {re_sum_q[SumW-1], re_sum_q} + Half;
            im_rnd = {im_sum_q[SumW-1], im_sum_q} + Half;
        end

        always_ff @(posedge iclk or negedge ireset) begin
            if (!ireset) begin
                re_out_q <= '0;
                im_out_q <= '0;
            end else if (iclkena) begin
                re_out_q <= re_rnd[Shift +: pODAT_W];
                im_out_q <= im_rnd[Shift +: pODAT_W];
            end
        end

        assign odat_re    = re_out_q;
        assign odat_im    = im_out_q;
        assign unused_rnd = ^{re_rnd, im_rnd};
    end else begin : g_trunc
        logic unused_sum;

        assign odat_re    = re_sum_q[Shift +: pODAT_W];
        assign odat_im    = im_sum_q[Shift +: pODAT_W];
        assign unused_sum = ^{re_sum_q, im_sum_q};
    end

    // Discarded product LSBs (pMUL_W > 0).
    logic unused_prod;
    assign unused_prod = ^{ac_full, bs_full, as_full, bc_full};

    // ---------------- valid pipeline ----------------
    logic [Lat-1:0] val_q;

    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            val_q <= '0;
        end else if (iclkena) begin
            val_q <= {val_q[Lat-2:0], ival};
        end
    end

    assign oval = val_q[Lat-1];

endmodule

// File: tb/tb_complex_mixer.sv
// Self-checking bench for complex_mixer.
// u_dut0 uses the default parameters: conjugate off, rounding on, latency 4.
// u_dut1 uses pCONJ=1 with truncation: latency 3.
// Both instances share the same stimulus. Expected results go into one queue per DUT
// when a sample is accepted. Each entry carries the enabled-cycle index at which the
// output must appear.
module tb_complex_mixer;

    localparam int L0 = 4;
    localparam int L1 = 3;

    logic iclk    = 1'b0;
    logic ireset  = 1'b0;
    logic iclkena = 1'b0;
    logic ival    = 1'b0;
    logic signed [15:0] idat_re = '0;
    logic signed [15:0] idat_im = '0;
    logic signed [16:0] icos    = '0;
    logic signed [16:0] isin    = '0;

    logic               oval0, oval1;
    logic signed [17:0] re0, im0, re1, im1;

    always #5 iclk = ~iclk;

    complex_mixer u_dut0 (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (ival),
        .idat_re (idat_re),
        .idat_im (idat_im),
        .icos    (icos),
        .isin    (isin),
        .oval    (oval0),
        .odat_re (re0),
        .odat_im (im0)
    );

    complex_mixer #(
        .pCONJ      (1),
        .pUSE_ROUND (0)
    ) u_dut1 (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (ival),
        .idat_re (idat_re),
        .idat_im (idat_im),
        .icos    (icos),
        .isin    (isin),
        .oval    (oval1),
        .odat_re (re1),
        .odat_im (im1)
    );

    typedef struct {
        logic signed [17:0] re;
        logic signed [17:0] im;
        int                 due;
    } exp_t;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [16:0] c;
        logic signed [16:0] s;
        logic signed [17:0] re;
        logic signed [17:0] im;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: exact 64-bit products and sums, then floor or round-half-up.
    function automatic void model(input logic signed [15:0] a, input logic signed [15:0] b,
                                  input logic signed [16:0] c, input logic signed [16:0] s,
                                  input bit conj, input bit rnd,
                                  output logic signed [17:0] re, output logic signed [17:0] im);
        longint ac, bs, as_, bc, r, i;
        ac  = longint'(a) * longint'(c);
        bs  = longint'(b) * longint'(s);
        as_ = longint'(a) * longint'(s);
        bc  = longint'(b) * longint'(c);
        r   = conj ? ac + bs : ac - bs;
        i   = conj ? bc - as_ : as_ + bc;
        if (rnd) begin
            r = r + 64'sd32768;
            i = i + 64'sd32768;
        end
        re = 18'(r >>> 16);
        im = 18'(i >>> 16);
    endfunction

    task automatic check_out();
        bit   v;
        exp_t e;
        v = (q0.size() > 0) && (q0[0].due == ecnt);
        check("dut0 oval", longint'(oval0), longint'(v));
        if (v) begin
            e = q0.pop_front();
            check("dut0 odat_re", longint'(re0), longint'(e.re));
            check("dut0 odat_im", longint'(im0), longint'(e.im));
        end
        v = (q1.size() > 0) && (q1[0].due == ecnt);
        check("dut1 oval", longint'(oval1), longint'(v));
        if (v) begin
            e = q1.pop_front();
            check("dut1 odat_re", longint'(re1), longint'(e.re));
            check("dut1 odat_im", longint'(im1), longint'(e.im));
        end
    endtask

    // Drives inputs for one clock (called just after a falling edge).
    // use_e selects the table's expected value for dut0 instead of the model result.
    task automatic tick(input bit en, input bit v, input vec_t x, input bit use_e);
        exp_t e;
        logic signed [17:0] mr, mi;
        iclkena = en;
        ival    = v;
        idat_re = x.a;
        idat_im = x.b;
        icos    = x.c;
        isin    = x.s;
        @(posedge iclk);
        if (en) ecnt++;
        if (en && v) begin
            model(x.a, x.b, x.c, x.s, 1'b0, 1'b1, mr, mi);
            e.re  = use_e ? x.re : mr;
            e.im  = use_e ? x.im : mi;
            e.due = ecnt + L0 - 1;
            q0.push_back(e);
            model(x.a, x.b, x.c, x.s, 1'b1, 1'b0, mr, mi);
            e.re  = mr;
            e.im  = mi;
            e.due = ecnt + L1 - 1;
            q1.push_back(e);
        end
        @(negedge iclk);
        if (en) check_out();
    endtask

    function automatic vec_t rand_vec();
        vec_t x;
        x.a  = 16'($urandom);
        x.b  = 16'($urandom);
        x.c  = 17'($urandom);
        x.s  = 17'($urandom);
        x.re = '0;
        x.im = '0;
        return x;
    endfunction

    task automatic idle(input int n);
        vec_t z;
        z = '{'0, '0, '0, '0, '0, '0};
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, z, 1'b0);
    endtask

    vec_t tbl[6];

    initial begin
        int   n;
        bit   en;
        vec_t x;

        tbl[0] = '{16'sd1000, 16'sd0, 17'sd32768, 17'sd0, 18'sd500, 18'sd0};
        tbl[1] = '{16'sd0, 16'sd1000, 17'sd0, 17'sd32768, -18'sd500, 18'sd0};
        tbl[2] = '{16'sd3, 16'sd0, 17'sd32768, 17'sd0, 18'sd2, 18'sd0};
        tbl[3] = '{-16'sd3, 16'sd0, 17'sd32768, 17'sd0, -18'sd1, 18'sd0};
        tbl[4] = '{16'h8000, 16'h8000, 17'h10000, 17'sd65535, 18'sd65536, 18'sd1};
        tbl[5] = '{16'sd1000, 16'sd0, 17'sd0, 17'sd32768, 18'sd0, 18'sd500};

        // Reset state.
        #1;
        check("reset oval0", longint'(oval0), 0);
        check("reset odat_re0", longint'(re0), 0);
        check("reset odat_im0", longint'(im0), 0);
        check("reset oval1", longint'(oval1), 0);
        @(negedge iclk);
        @(negedge iclk);
        ireset = 1'b1;
        idle(3);

        // Single isolated sample: exactly L cycles of latency and a one-cycle pulse.
        tick(1'b1, 1'b1, tbl[0], 1'b1);
        idle(6);

        // Table vectors, back to back.
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, tbl[i], 1'b1);
        idle(6);

        // Table vectors again with gaps and the enable dropped.
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, tbl[i], 1'b1);
            tick(1'b1, 1'b1, tbl[i], 1'b1);
            tick(1'b0, 1'b0, tbl[i], 1'b1);
        end
        idle(6);

        // 100 streaming random samples with iclkena toggled pseudo-randomly.
        n = 0;
        while (n < 100) begin
            en = ($urandom_range(0, 3) != 0);
            x  = rand_vec();
            tick(en, 1'b1, x, 1'b0);
            if (en) n++;
        end
        idle(8);
        check("queue0 drained", longint'(q0.size()), 0);
        check("queue1 drained", longint'(q1.size()), 0);

        // Reset asserted mid-stream.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, rand_vec(), 1'b0);
        #2;
        ireset = 1'b0;
        #1;
        check("async reset oval0", longint'(oval0), 0);
        check("async reset odat_re0", longint'(re0), 0);
        check("async reset odat_im0", longint'(im0), 0);
        check("async reset oval1", longint'(oval1), 0);
        check("async reset odat_re1", longint'(re1), 0);
        q0.delete();
        q1.delete();
        iclkena = 1'b1;
        ival    = 1'b1;
        @(negedge iclk);
        @(negedge iclk);
        ival   = 1'b0;
        ireset = 1'b1;
        idle(6);
        tick(1'b1, 1'b1, tbl[4], 1'b1);
        idle(6);
        check("final queue0 drained", longint'(q0.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
